keypad_scan_debounce: RTL

- Scans the 4x4 matrix keypad on the board and debounces it.
- Presents a stable 5-bit key word to the IO bridge's keyboard input, plus a one-cycle press event.
- Sits between the keypad pins (row/col) and the IO bridge.
- Runs on the CPU clock `clk` and replaces the bare scanner currently instanced at the top level.

---
 rtl/keypad_scan_debounce_pkg.sv | 36 +++
 rtl/keypad_scan_debounce_frame_classifier.sv | 37 +++
 rtl/keypad_scan_debounce.sv | 137 +++++++++++++
 3 files changed

// File: rtl/keypad_scan_debounce_pkg.sv
// Shared definitions for the keypad scanner: key word width, the
// row/column-to-code lookup, the frame-class encoding and the debounce
// state encoding.
package keypad_scan_debounce_pkg;

    localparam int KEY_WORD_LEN = 5;
    localparam int KP_ROWS      = 4;
    localparam int KP_COLS      = 4;

    // Frame accumulator bit index is row*4 + col (row-major). Entry 0 is
    // the rightmost nibble, so the list reads r3c3 .. r0c0.
    //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: E(*) 0 F(#) D
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    typedef enum logic [1:0] {
        FRAME_NONE   = 2'd0,
        FRAME_SINGLE = 2'd1,
        FRAME_MULTI  = 2'd2
    } frame_class_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESSED = 1'b1
    } deb_state_e;

    typedef struct packed {
        frame_class_e cls;
        logic [3:0]   code;
    } frame_result_t;

endpackage

// File: rtl/keypad_scan_debounce_frame_classifier.sv
// keypad_frame_classifier: combinational classification of one full scan
// frame.
//   frame  : 16 active-high key bits, index row*4 + col
//   result : {class, code}; code is only meaningful for FRAME_SINGLE and
//            is forced to 0 otherwise so results compare cleanly.
module keypad_frame_classifier
    import keypad_scan_debounce_pkg::*;
(
    input  logic [15:0]   frame,
    output frame_result_t result
);

    logic [4:0] ones;
    logic [3:0] idx;

    always_comb begin
        ones = '0;
        idx  = '0;
        for (int i = 0; i < 16; i++) begin
            if (frame[i]) begin
                ones = ones + 5'd1;
                idx  = 4'(i);
            end
        end

        result.code = 4'h0;
        if (ones == 5'd0) begin
            result.cls = FRAME_NONE;
        end else if (ones == 5'd1) begin
            result.cls  = FRAME_SINGLE;
            result.code = KEY_MAP[idx];
        end else begin
            result.cls = FRAME_MULTI;
        end
    end

endmodule

// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce: scans a 4x4 active-low matrix keypad, classifies each
// full frame and debounces the result into a stable key word.
//   clk       : CPU clock
//   rst       : asynchronous active-high reset
//   row       : keypad rows, active-low, asynchronous to clk
//   col       : column drive, one-hot active-low
//   key       : {pressed, code[3:0]}
//   key_event : one-cycle pulse on each newly accepted press
module keypad_scan_debounce
    import keypad_scan_debounce_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [KP_ROWS-1:0]      row,
    output logic [KP_COLS-1:0]      col,
    output logic [KEY_WORD_LEN-1:0] key,
    output logic                    key_event
);

    localparam int         DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0] DEB_N    = 4'(DEBOUNCE_SCANS);

    // ---------------- row synchronizer ----------------
    logic [KP_ROWS-1:0] row_s1, row_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1 <= '1;
            row_s2 <= '1;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
        end
    end

    // ---------------- column sequencer ----------------
    logic [DIV_W-1:0] div;
    logic [1:0]       col_idx;
    logic [1:0]       col_idx_next;
    logic [15:0]      acc;
    logic [15:0]      frame_now;
    logic             tick;
    logic             frame_end;

    assign tick         = (div == DIV_LAST);
    assign frame_end    = tick && (col_idx == 2'd3);
    assign col_idx_next = col_idx + 2'd1;

    // Accumulator plus the column currently being sampled, so the frame-end
    // classification sees column 3's rows without an extra cycle.
    always_comb begin
        frame_now = acc;
        for (int r = 0; r < KP_ROWS; r++) begin
            if (!row_s2[r]) frame_now[{2'(r), col_idx}] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div     <= '0;
            col_idx <= 2'd0;
            col     <= 4'b1110;
            acc     <= '0;
        end else if (tick) begin
            div     <= '0;
            col_idx <= col_idx_next;
            col     <= ~(4'b0001 << col_idx_next);
            acc     <= frame_end ? 16'h0000 : frame_now;
        end else begin
            div     <= div + DIV_W'(1);
        end
    end

    // ---------------- frame classification ----------------
    frame_result_t res;

    keypad_frame_classifier u_classifier (
        .frame  (frame_now),
        .result (res)
    );

    // ---------------- debounce ----------------
    frame_result_t cand;
    logic [3:0]    cnt;
    logic [3:0]    cnt_next;
    logic          same;
    logic          accept;
    deb_state_e    state;

    assign same     = (res == cand);
    assign cnt_next = !same ? 4'd1 : ((cnt == DEB_N) ? cnt : cnt + 4'd1);
    // Accept only on the frame where the run first reaches the threshold;
    // a saturated run of the same result does not re-accept.
    assign accept   = frame_end && (cnt_next == DEB_N) && !(same && cnt == DEB_N);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cand      <= '{cls: FRAME_NONE, code: 4'h0};
            cnt       <= 4'd0;
            key       <= '0;
            key_event <= 1'b0;
        end else begin
            key_event <= 1'b0;
            if (frame_end) begin
                cand <= res;
                cnt  <= cnt_next;
                if (accept) begin
                    case (state)
                        ST_IDLE: begin
                            if (res.cls == FRAME_SINGLE) begin
                                state     <= ST_PRESSED;
                                key       <= {1'b1, res.code};
                                key_event <= 1'b1;
                            end
                        end
                        ST_PRESSED: begin
                            if (res.cls == FRAME_SINGLE && res.code != key[3:0]) begin
                                key       <= {1'b1, res.code};
                                key_event <= 1'b1;
                            end else if (res.cls == FRAME_NONE) begin
                                state  <= ST_IDLE;
                                key[4] <= 1'b0;
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule
